// File: rtl/run_det_pkg.sv
// Shared types and mode constants for the run detector and its occurrence counter.
package run_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      FULL = 2'd2
   } run_state_e;

   localparam logic MODE_OVERLAP = 1'b1;
   localparam logic MODE_NONOVL  = 1'b0;

endpackage

// File: rtl/run_detect_counter_occ_counter.sv
// Occurrence counter with sticky overflow. Define RUN_DET_SAT_EN to saturate
// at all-ones instead of wrapping to zero.
module occ_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Next count: clear wins, then one step per detection.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = {CNT_W{1'b0}};
         ovf_d   = 1'b0;
      end else if (inc) begin
         if (count_q == CNT_MAX) begin
`ifdef RUN_DET_SAT_EN
            count_d = count_q;
`else
            count_d = {CNT_W{1'b0}};
`endif
            ovf_d   = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         count_d = count_q;
         ovf_d   = ovf_q;
      end
   end

   // Count and overflow registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= {CNT_W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/run_detect_counter.sv
// Detects runs of RUN_LEN bits equal to target, overlapping or not, and counts them.
// Build option: RUN_DET_SAT_EN makes the occurrence count saturate instead of wrap.
module run_detect_counter
   import run_det_pkg::*;
#(
   parameter  int RUN_LEN = 3,
   parameter  int CNT_W   = 8,
   localparam int RW      = $clog2(RUN_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in,
   input  logic             target,
   input  logic             overlap,
   output logic             hit,
   output logic [CNT_W-1:0] count,
   output logic [RW-1:0]    run_cur,
   output logic             overflow
);

   localparam logic [RW-1:0] RUN_LEN_V = RW'(RUN_LEN);

   run_state_e      state_q, state_d;
   logic [RW-1:0]   run_q, run_d, run_inc;
   logic            hit_q, hit_d;

   assign run_inc = run_q + RW'(1);

   // Next state; hit_d also drives the counter so count tracks hit on the same edge.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      hit_d   = 1'b0;
      if (clr) begin
         state_d = IDLE;
         run_d   = {RW{1'b0}};
      end else if (in_valid) begin
         if (in != target) begin
            state_d = IDLE;
            run_d   = {RW{1'b0}};
         end else begin
            case (state_q)
               IDLE, ACC: begin
                  if (run_inc == RUN_LEN_V) begin
                     hit_d = 1'b1;
                     if (overlap == MODE_OVERLAP) begin
                        state_d = FULL;
                        run_d   = RUN_LEN_V;
                     end else begin
                        state_d = IDLE;
                        run_d   = {RW{1'b0}};
                     end
                  end else begin
                     state_d = ACC;
                     run_d   = run_inc;
                  end
               end
               FULL: begin
                  hit_d = 1'b1;
                  if (overlap == MODE_OVERLAP) begin
                     state_d = FULL;
                     run_d   = RUN_LEN_V;
                  end else begin
                     state_d = IDLE;
                     run_d   = {RW{1'b0}};
                  end
               end
               default: begin
                  state_d = IDLE;
                  run_d   = {RW{1'b0}};
               end
            endcase
         end
      end else begin
         state_d = state_q;
         run_d   = run_q;
      end
   end

   // FSM, run length and hit pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         run_q   <= {RW{1'b0}};
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         hit_q   <= hit_d;
      end
   end

   occ_counter #(.CNT_W(CNT_W)) u_occ_counter (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .inc      (hit_d),
      .count    (count),
      .overflow (overflow)
   );

   assign hit     = hit_q;
   assign run_cur = run_q;

endmodule

// File: tb/tb_run_detect_counter.sv
// Self-checking bench for run_detect_counter (RUN_LEN=3, CNT_W=4); honours RUN_DET_SAT_EN.
module tb_run_detect_counter;

   localparam int RUN_LEN = 3;
   localparam int CNT_W   = 4;
   localparam int RW      = $clog2(RUN_LEN + 1);
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic             in = 1'b0;
   logic             target = 1'b0;
   logic             overlap = 1'b1;
   logic             hit;
   logic [CNT_W-1:0] count;
   logic [RW-1:0]    run_cur;
   logic             overflow;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: plain integers.
   int m_run = 0;
   int m_cnt = 0;
   int m_ovf = 0;
   int m_hit = 0;

   run_detect_counter #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .in_valid (in_valid),
      .in       (in),
      .target   (target),
      .overlap  (overlap),
      .hit      (hit),
      .count    (count),
      .run_cur  (run_cur),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_run = 0; m_cnt = 0; m_ovf = 0; m_hit = 0;
   endtask

   // Drive one cycle, wait past the edge, then advance the model.
   task automatic step(input logic v, input logic b, input logic t, input logic o, input logic c);
      in_valid = v; in = b; target = t; overlap = o; clr = c;
      @(posedge clk);
      #1;
      m_hit = 0;
      if (c) begin
         model_reset();
      end else if (v) begin
         if (b != t) begin
            m_run = 0;
         end else begin
            m_run = m_run + 1;
            if (m_run >= RUN_LEN) begin
               m_hit = 1;
               if (m_cnt + 1 > CMAX) m_ovf = 1;
`ifdef RUN_DET_SAT_EN
               m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
`else
               m_cnt = (m_cnt + 1) % (CMAX + 1);
`endif
               m_run = o ? RUN_LEN : 0;
            end
         end
      end
      in_valid = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (hit !== 1'b0 || count !== 4'd0 || run_cur !== 2'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset: hit=%b count=%0d run=%0d ovf=%b, required all 0", hit, count, run_cur, overflow);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_overlap();
      logic b_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic h_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int   r_exp [6] = '{0, 1, 2, 3, 3, 0};
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, b_seq[i], 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (hit !== h_exp[i] || int'(run_cur) != r_exp[i]) begin
            n_err++;
            $display("FAIL overlap[%0d]: hit=%b run=%0d, required hit=%b run=%0d", i, hit, run_cur, h_exp[i], r_exp[i]);
         end
      end
      n_cmp++;
      if (count !== 4'd2) begin
         n_err++;
         $display("FAIL overlap_count: got %0d, required 2", count);
      end
   endtask

   task automatic test_nonoverlap();
      logic h_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int   r_exp [6] = '{1, 2, 0, 1, 2, 0};
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (hit !== h_exp[i] || int'(run_cur) != r_exp[i]) begin
            n_err++;
            $display("FAIL nonoverlap[%0d]: hit=%b run=%0d, required hit=%b run=%0d", i, hit, run_cur, h_exp[i], r_exp[i]);
         end
      end
      n_cmp++;
      if (count !== 4'd2) begin
         n_err++;
         $display("FAIL nonoverlap_count: got %0d, required 2", count);
      end
   endtask

   task automatic test_valid_gaps();
      logic v_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic b_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic h_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int   r_exp [5] = '{1, 1, 2, 2, 3};
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(v_seq[i], b_seq[i], 1'b1, 1'b1, 1'b0);
         n_cmp++;
         if (hit !== h_exp[i] || int'(run_cur) != r_exp[i]) begin
            n_err++;
            $display("FAIL valid_gaps[%0d]: hit=%b run=%0d, required hit=%b run=%0d", i, hit, run_cur, h_exp[i], r_exp[i]);
         end
      end
      n_cmp++;
      if (count !== 4'd1) begin
         n_err++;
         $display("FAIL valid_gaps_count: got %0d, required 1", count);
      end
   endtask

   task automatic test_counter_wrap();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (count !== 4'd15 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_pre: count=%0d ovf=%b, required 15/0", count, overflow);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
`ifdef RUN_DET_SAT_EN
      if (count !== 4'd15 || overflow !== 1'b1 || hit !== 1'b1) begin
         n_err++;
         $display("FAIL sat: count=%0d ovf=%b hit=%b, required 15/1/1", count, overflow, hit);
      end
`else
      if (count !== 4'd0 || overflow !== 1'b1 || hit !== 1'b1) begin
         n_err++;
         $display("FAIL wrap: count=%0d ovf=%b hit=%b, required 0/1/1", count, overflow, hit);
      end
`endif
   endtask

   task automatic test_clr();
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (hit !== 1'b0 || count !== 4'd0 || run_cur !== 2'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL clr: hit=%b count=%0d run=%0d ovf=%b, required all 0", hit, count, run_cur, overflow);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (hit !== 1'b0 || run_cur !== 2'd1) begin
         n_err++;
         $display("FAIL clr_after: hit=%b run=%0d, required 0/1", hit, run_cur);
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (hit !== 1'b1 || count === 4'd0) begin
         n_err++;
         $display("FAIL async_pre: hit=%b count=%0d, required hit=1 and nonzero count", hit, count);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (hit !== 1'b0 || count !== 4'd0 || run_cur !== 2'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: hit=%b count=%0d run=%0d ovf=%b, required all 0", hit, count, run_cur, overflow);
      end
      #1 reset = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (hit !== (i == 2) || int'(run_cur) != i + 1) begin
            n_err++;
            $display("FAIL async_after[%0d]: hit=%b run=%0d, required hit=%b run=%0d", i, hit, run_cur, (i == 2), i + 1);
         end
      end
   endtask

   task automatic test_random();
      logic t = 1'b0;
      logic o = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) t = ~t;
         if ($urandom_range(0, 7) == 0) o = ~o;
         step(logic'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0) ? t : logic'($urandom_range(0, 1)),
              t, o, logic'($urandom_range(0, 63) == 0));
         n_cmp++;
         if (int'(hit) != m_hit || int'(count) != m_cnt || int'(run_cur) != m_run || int'(overflow) != m_ovf) begin
            n_err++;
            $display("FAIL random[%0d]: hit=%b count=%0d run=%0d ovf=%b, required %0d/%0d/%0d/%0d",
                     i, hit, count, run_cur, overflow, m_hit, m_cnt, m_run, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_valid_gaps();
      test_counter_wrap();
      test_clr();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
